// File: rtl/mult_accum_pkg.sv
// Shared definitions for the multiply-accumulate block: FSM state encoding
// and default widths.
package mult_accum_pkg;

  localparam int ACC_W_DEF = 36;
  localparam int CNT_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage : mult_accum_pkg

// File: rtl/mult_accum_adder.sv
// Parameterised n-bit ripple adder with carry in and carry out. The carry
// out is what the accumulator uses to detect wrap past 2^n.
module acc_adder #(
  parameter int N = 36
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);

  // Single wide add; the extra MSB captures the carry out.
  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};

endmodule : acc_adder

// File: rtl/mult_accum.sv
// Accumulates a host-specified number of 32-bit unsigned products into an
// ACC_W-bit sum, flagging wrap-around, and presents the result with a
// valid/ready handshake.
module mult_accum
  import mult_accum_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic [31:0]      prod,
  input  logic             prod_valid,
  output logic             prod_ready,
  output logic [ACC_W-1:0] res,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             ovf,
  output logic             busy
);

  state_e           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;

  logic [ACC_W-1:0] prod_ext;
  logic [ACC_W-1:0] sum;
  logic             carry;
  logic             beat;

  // Products are unsigned, so widen with zeros to the accumulator width.
  assign prod_ext = ACC_W'(prod);

  acc_adder #(
    .N (ACC_W)
  ) u_adder (
    .a    (acc_q),
    .b    (prod_ext),
    .cin  (1'b0),
    .sum  (sum),
    .cout (carry)
  );

  // Handshake and status outputs decode directly from the current state.
  assign prod_ready = (state_q == ACCUM);
  assign res_valid  = (state_q == DONE);
  assign busy       = (state_q != IDLE);
  assign res        = acc_q;
  assign ovf        = ovf_q;
  assign beat       = prod_valid && prod_ready;

  // State and datapath registers; reset discards any partial sum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  // Next-state and datapath update; start is only looked at in IDLE.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          acc_d   = '0;
          ovf_d   = 1'b0;
          cnt_d   = len;
          // A zero-length request has nothing to add; report 0 straight away.
          state_d = (len == '0) ? DONE : ACCUM;
        end
      end
      ACCUM: begin
        if (beat) begin
          acc_d = sum;
          ovf_d = ovf_q | carry;
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (res_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule : mult_accum

// File: tb/tb_mult_accum.sv
// Scoreboard bench for mult_accum: expected sums are pushed when a run is
// started and popped when the DUT completes a result handshake.
module tb_mult_accum;

  localparam int ACC_W = 36;
  localparam int CNT_W = 8;

  typedef struct {
    logic [ACC_W-1:0] acc;
    logic             ovf;
  } exp_t;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [CNT_W-1:0] len;
  logic [31:0]      prod;
  logic             prod_valid;
  logic             prod_ready;
  logic [ACC_W-1:0] res;
  logic             res_valid;
  logic             res_ready;
  logic             ovf;
  logic             busy;

  exp_t        sb_q[$];
  logic [31:0] pv [0:31];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          beats_seen = 0;
  int          ready_cycles = 0;

  mult_accum #(
    .ACC_W (ACC_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .len        (len),
    .prod       (prod),
    .prod_valid (prod_valid),
    .prod_ready (prod_ready),
    .res        (res),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .ovf        (ovf),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, expv, $time);
    end
  endtask

  // Reference model: sum of the first n entries of pv, modulo 2^ACC_W.
  function automatic exp_t model(input int n);
    exp_t        e;
    logic [ACC_W:0] s;
    e.acc = '0;
    e.ovf = 1'b0;
    for (int i = 0; i < n; i++) begin
      s = {1'b0, e.acc} + {{(ACC_W-31){1'b0}}, pv[i]};
      if (s[ACC_W]) e.ovf = 1'b1;
      e.acc = s[ACC_W-1:0];
    end
    return e;
  endfunction

  // Output monitor: beat counting, exclusivity, and scoreboard pops.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (prod_ready) ready_cycles++;
        if (prod_valid && prod_ready) beats_seen++;
        if (res_valid) chk("ready_valid_excl", 64'(prod_ready), 64'd0);
        if (res_valid && res_ready) begin
          if (sb_q.size() == 0) begin
            chk("unexpected_res", 64'd1, 64'd0);
          end else begin
            e = sb_q.pop_front();
            $display("result: res=0x%0h ovf=%0b (expected 0x%0h/%0b)", res, ovf, e.acc, e.ovf);
            chk("res", 64'(res), 64'(e.acc));
            chk("ovf", 64'(ovf), 64'(e.ovf));
          end
        end
      end
    end
  end

  // All tasks start and end at 1 time unit after a rising edge.
  task automatic send_beat(input logic [31:0] p);
    int to = 0;
    prod_valid = 1'b1;
    prod       = p;
    while (!prod_ready && to < 20) begin
      @(posedge clk); #1;
      to++;
    end
    if (to >= 20) chk("ready_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    prod_valid = 1'b0;
    prod       = $urandom;
  endtask

  task automatic start_run(input int n);
    sb_q.push_back(model(n));
    start = 1'b1;
    len   = CNT_W'(n);
    @(posedge clk); #1;
    start = 1'b0;
    len   = CNT_W'($urandom);
  endtask

  task automatic run_op(input int n, input int gap_at, input int gap_len, input int hold);
    int          b0 = beats_seen;
    int          r0 = ready_cycles;
    int          to = 0;
    logic [ACC_W-1:0] held;
    start_run(n);
    for (int i = 0; i < n; i++) begin
      if (i == gap_at) begin
        repeat (gap_len) begin
          @(posedge clk); #1;
        end
      end
      send_beat(pv[i]);
    end
    // Result must be valid in the cycle right after the final beat.
    chk("latency", 64'(res_valid), 64'd1);
    if (hold > 0) begin
      res_ready = 1'b0;
      held = res;
      for (int k = 0; k < hold; k++) begin
        if (k == 2) begin
          start = 1'b1;
          len   = 8'd9;
        end
        @(posedge clk); #1;
        start = 1'b0;
        chk("hold_res", 64'(res), 64'(held));
        chk("hold_valid", 64'(res_valid), 64'd1);
      end
      res_ready = 1'b1;
      @(posedge clk); #1;
      chk("idle_after_ready", 64'(busy), 64'd0);
    end else begin
      while (busy && to < 50) begin
        @(posedge clk); #1;
        to++;
      end
      if (to >= 50) chk("done_timeout", 64'd0, 64'd1);
    end
    chk("beat_count", 64'(beats_seen - b0), 64'(n));
    if (n == 0) chk("len0_no_ready", 64'(ready_cycles - r0), 64'd0);
  endtask

  initial begin
    rst_n      = 1'b0;
    start      = 1'b0;
    len        = '0;
    prod       = '0;
    prod_valid = 1'b0;
    res_ready  = 1'b1;

    #12;
    chk("rst_res_valid", 64'(res_valid), 64'd0);
    chk("rst_prod_ready", 64'(prod_ready), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_res", 64'(res), 64'd0);

    // Release reset and request a run on the very first edge.
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) pv[i] = 32'd2500;
    run_op(3, -1, 0, 0);

    // Bubbles of two cycles between beats 2 and 3.
    pv[0] = 32'd10; pv[1] = 32'd20; pv[2] = 32'd30; pv[3] = 32'd40;
    run_op(4, 2, 2, 0);

    // Wrap past 2^36.
    for (int i = 0; i < 17; i++) pv[i] = 32'hFFFF_FFFF;
    run_op(17, -1, 0, 0);

    // Zero-length request.
    run_op(0, -1, 0, 0);

    // Result held while consumer stalls, start pulsed during the stall.
    pv[0] = 32'h1234_5678; pv[1] = 32'h0BAD_F00D;
    run_op(2, -1, 0, 5);

    // A few random runs with random bubble placement.
    for (int r = 0; r < 3; r++) begin
      int n = $urandom_range(1, 8);
      for (int i = 0; i < n; i++) pv[i] = $urandom;
      run_op(n, $urandom_range(0, n - 1), $urandom_range(0, 3), 0);
    end

    // Reset in the middle of a run: partial sum discarded, no result.
    for (int i = 0; i < 5; i++) pv[i] = 32'd1000;
    start_run(5);
    send_beat(pv[0]);
    send_beat(pv[1]);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_prod_ready", 64'(prod_ready), 64'd0);
    chk("abort_res_valid", 64'(res_valid), 64'd0);
    chk("abort_res", 64'(res), 64'd0);
    void'(sb_q.pop_back());
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    pv[0] = 32'd7;
    run_op(1, -1, 0, 0);

    repeat (4) @(posedge clk);
    #1;
    chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_mult_accum
